// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU opcodes, shift types, condition codes,
// NZCV flag bit positions and the condition-code evaluator.
package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_CMP = 3'b110;
  localparam logic [2:0] ALU_MVN = 3'b111;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v, p;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cc)
      COND_EQ: p = z;
      COND_NE: p = ~z;
      COND_CS: p = c;
      COND_CC: p = ~c;
      COND_MI: p = n;
      COND_PL: p = ~n;
      COND_VS: p = v;
      COND_VC: p = ~v;
      COND_HI: p = c & ~z;
      COND_LS: p = ~c | z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = ~z & (n == v);
      COND_LE: p = z | (n != v);
      COND_AL: p = 1'b1;
      COND_NV: p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// Combinational shifter and ALU. For CMP the N/Z outputs describe A-B while the
// result passes A through unchanged.
module alu16
  import ex_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] opb0,
  input  logic          alu_shift,
  input  logic [1:0]    shift_type,
  input  logic [3:0]    shamt,
  input  logic [2:0]    aluop,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z,
  output logic          c,
  output logic          v,
  output logic          arith
);

  logic [DW-1:0]   b_s;
  logic [2*DW-1:0] rot_s;
  logic [DW:0]     sum_s;
  logic [DW:0]     diff_s;
  logic [DW-1:0]   val_s;

  // Barrel shifter on operand B; rotation via a doubled word so amount 0 is a no-op
  always_comb begin
    rot_s = {opb0, opb0} >> shamt;
    b_s   = opb0;
    if (alu_shift) begin
      case (shift_type)
        SH_LSL:  b_s = opb0 << shamt;
        SH_LSR:  b_s = opb0 >> shamt;
        SH_ASR:  b_s = $signed(opb0) >>> shamt;
        SH_ROR:  b_s = rot_s[DW-1:0];
        default: b_s = opb0;
      endcase
    end else begin
      b_s = opb0;
    end
  end

  assign sum_s  = {1'b0, a} + {1'b0, b_s};
  assign diff_s = {1'b0, a} + {1'b0, ~b_s} + {{DW{1'b0}}, 1'b1};

  // Operation select; carry/overflow only meaningful for the arithmetic group
  always_comb begin
    val_s = {DW{1'b0}};
    c     = 1'b0;
    v     = 1'b0;
    arith = 1'b0;
    case (aluop)
      ALU_ADD: begin
        val_s = sum_s[DW-1:0];
        c     = sum_s[DW];
        v     = (a[DW-1] == b_s[DW-1]) && (sum_s[DW-1] != a[DW-1]);
        arith = 1'b1;
      end
      ALU_SUB, ALU_CMP: begin
        val_s = diff_s[DW-1:0];
        c     = diff_s[DW];
        v     = (a[DW-1] != b_s[DW-1]) && (diff_s[DW-1] != a[DW-1]);
        arith = 1'b1;
      end
      ALU_AND: val_s = a & b_s;
      ALU_ORR: val_s = a | b_s;
      ALU_EOR: val_s = a ^ b_s;
      ALU_MOV: val_s = b_s;
      ALU_MVN: val_s = ~b_s;
      default: val_s = {DW{1'b0}};
    endcase
  end

  assign n      = val_s[DW-1];
  assign z      = (val_s == {DW{1'b0}});
  assign result = (aluop == ALU_CMP) ? a : val_s;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, NZCV register, branch resolution and the
// EX/MEM pipeline register. A registered taken branch squashes the next instruction.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWrite_n,
  input  logic          ALUsrc_n,
  input  logic [1:0]    shift_type_n,
  input  logic [2:0]    ALUop_n,
  input  logic [3:0]    conditions_n,
  input  logic          mem_read_n,
  input  logic          mem_write_n,
  input  logic [1:0]    write_back_n,
  input  logic          cond_branch_n,
  input  logic          uncond_branch_n,
  input  logic          link_branch_n,
  input  logic          reg_branch_n,
  input  logic [AW-1:0] read_address1_n,
  input  logic [AW-1:0] read_address2_n,
  input  logic [AW-1:0] write_address_n,
  input  logic [DW-1:0] read_data1_n,
  input  logic [DW-1:0] read_data2_n,
  input  logic [DW-1:0] immediate_data_n,
  input  logic [DW-1:0] link_pc_n,
  input  logic          alu_shift_n,
  input  logic          memwb_RegWrite,
  input  logic [AW-1:0] memwb_write_address,
  input  logic [DW-1:0] memwb_write_data,
  output logic          RegWrite_m,
  output logic          mem_read_m,
  output logic          mem_write_m,
  output logic [1:0]    write_back_m,
  output logic [AW-1:0] write_address_m,
  output logic [DW-1:0] alu_result_m,
  output logic [DW-1:0] store_data_m,
  output logic [DW-1:0] link_pc_m,
  output logic          branch_taken_m,
  output logic [DW-1:0] branch_target_m,
  output logic [3:0]    flags
);

  logic          squash_s;
  logic [DW-1:0] fwd_a_s, fwd_b_s, opb0_s, alu_res_s, target_s;
  logic          alu_n_s, alu_z_s, alu_c_s, alu_v_s, alu_arith_s;
  logic          taken_s;
  logic [3:0]    flags_next_s;

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr, input logic [DW-1:0] rd);
    logic [DW-1:0] val;
    if (RegWrite_m && (write_address_m == addr)) begin
      val = alu_result_m;
    end else if (memwb_RegWrite && (memwb_write_address == addr)) begin
      val = memwb_write_data;
    end else begin
      val = rd;
    end
    return val;
  endfunction

  assign squash_s = branch_taken_m;
  assign fwd_a_s  = fwd(read_address1_n, read_data1_n);
  assign fwd_b_s  = fwd(read_address2_n, read_data2_n);
  assign opb0_s   = ALUsrc_n ? immediate_data_n : fwd_b_s;

  alu16 #(.DW(DW)) u_alu (
    .a          (fwd_a_s),
    .opb0       (opb0_s),
    .alu_shift  (alu_shift_n),
    .shift_type (shift_type_n),
    .shamt      (immediate_data_n[3:0]),
    .aluop      (ALUop_n),
    .result     (alu_res_s),
    .n          (alu_n_s),
    .z          (alu_z_s),
    .c          (alu_c_s),
    .v          (alu_v_s),
    .arith      (alu_arith_s)
  );

  assign taken_s  = ~squash_s & (uncond_branch_n | link_branch_n | reg_branch_n |
                                 (cond_branch_n & cond_pass(flags, conditions_n)));
  assign target_s = reg_branch_n ? fwd_a_s : (link_pc_n + immediate_data_n);

  // Next flag value; logical ops keep C/V, bubbles and wrong-path ops keep everything
  always_comb begin
    flags_next_s = flags;
    if (~squash_s && (RegWrite_n || (ALUop_n == ALU_CMP))) begin
      flags_next_s[FLAG_N] = alu_n_s;
      flags_next_s[FLAG_Z] = alu_z_s;
      if (alu_arith_s) begin
        flags_next_s[FLAG_C] = alu_c_s;
        flags_next_s[FLAG_V] = alu_v_s;
      end else begin
        flags_next_s[FLAG_C] = flags[FLAG_C];
        flags_next_s[FLAG_V] = flags[FLAG_V];
      end
    end else begin
      flags_next_s = flags;
    end
  end

  // EX/MEM register and flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_m      <= 1'b0;
      mem_read_m      <= 1'b0;
      mem_write_m     <= 1'b0;
      write_back_m    <= 2'b00;
      write_address_m <= {AW{1'b0}};
      alu_result_m    <= {DW{1'b0}};
      store_data_m    <= {DW{1'b0}};
      link_pc_m       <= {DW{1'b0}};
      branch_taken_m  <= 1'b0;
      branch_target_m <= {DW{1'b0}};
      flags           <= 4'b0000;
    end else if (squash_s) begin
      RegWrite_m      <= 1'b0;
      mem_read_m      <= 1'b0;
      mem_write_m     <= 1'b0;
      write_back_m    <= 2'b00;
      write_address_m <= {AW{1'b0}};
      alu_result_m    <= {DW{1'b0}};
      store_data_m    <= {DW{1'b0}};
      link_pc_m       <= {DW{1'b0}};
      branch_taken_m  <= 1'b0;
      branch_target_m <= {DW{1'b0}};
      flags           <= flags_next_s;
    end else begin
      RegWrite_m      <= RegWrite_n;
      mem_read_m      <= mem_read_n;
      mem_write_m     <= mem_write_n;
      write_back_m    <= write_back_n;
      write_address_m <= write_address_n;
      alu_result_m    <= alu_res_s;
      store_data_m    <= fwd_b_s;
      link_pc_m       <= link_pc_n;
      branch_taken_m  <= taken_s;
      branch_target_m <= target_s;
      flags           <= flags_next_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_n, ALUsrc_n, mem_read_n, mem_write_n;
  logic [1:0]  shift_type_n, write_back_n;
  logic [2:0]  ALUop_n;
  logic [3:0]  conditions_n;
  logic        cond_branch_n, uncond_branch_n, link_branch_n, reg_branch_n, alu_shift_n;
  logic [3:0]  read_address1_n, read_address2_n, write_address_n;
  logic [15:0] read_data1_n, read_data2_n, immediate_data_n, link_pc_n;
  logic        memwb_RegWrite;
  logic [3:0]  memwb_write_address;
  logic [15:0] memwb_write_data;
  logic        RegWrite_m, mem_read_m, mem_write_m, branch_taken_m;
  logic [1:0]  write_back_m;
  logic [3:0]  write_address_m, flags;
  logic [15:0] alu_result_m, store_data_m, link_pc_m, branch_target_m;

  int checks = 0;
  int errors = 0;

  // Model of what the outputs must hold after the most recent edge
  logic        m_rw, m_mr, m_mw, m_tk;
  logic [1:0]  m_wb;
  logic [3:0]  m_wa, m_fl;
  logic [15:0] m_alu, m_sd, m_lpc, m_tgt;

  ex_stage #(.DW(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_n(RegWrite_n), .ALUsrc_n(ALUsrc_n), .shift_type_n(shift_type_n),
    .ALUop_n(ALUop_n), .conditions_n(conditions_n), .mem_read_n(mem_read_n),
    .mem_write_n(mem_write_n), .write_back_n(write_back_n), .cond_branch_n(cond_branch_n),
    .uncond_branch_n(uncond_branch_n), .link_branch_n(link_branch_n),
    .reg_branch_n(reg_branch_n), .read_address1_n(read_address1_n),
    .read_address2_n(read_address2_n), .write_address_n(write_address_n),
    .read_data1_n(read_data1_n), .read_data2_n(read_data2_n),
    .immediate_data_n(immediate_data_n), .link_pc_n(link_pc_n), .alu_shift_n(alu_shift_n),
    .memwb_RegWrite(memwb_RegWrite), .memwb_write_address(memwb_write_address),
    .memwb_write_data(memwb_write_data),
    .RegWrite_m(RegWrite_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .write_back_m(write_back_m), .write_address_m(write_address_m),
    .alu_result_m(alu_result_m), .store_data_m(store_data_m), .link_pc_m(link_pc_m),
    .branch_taken_m(branch_taken_m), .branch_target_m(branch_target_m), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] addr, input logic [15:0] rd);
    if (m_rw && m_wa == addr) return m_alu;
    if (memwb_RegWrite && memwb_write_address == addr) return memwb_write_data;
    return rd;
  endfunction

  function automatic logic [15:0] shiftv(input logic [15:0] x, input logic [1:0] t, input int s);
    int ux;
    int sx;
    ux = x;
    sx = $signed(x);
    case (t)
      2'd0:    return 16'(ux << s);
      2'd1:    return 16'(ux >> s);
      2'd2:    return 16'(sx >>> s);
      default: return 16'((ux >> s) | (ux << (16 - s)));
    endcase
  endfunction

  // Conditions come in complementary pairs: the low bit inverts the base test
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic clr();
    RegWrite_n = 1'b0; ALUsrc_n = 1'b0; shift_type_n = 2'd0; ALUop_n = 3'd0;
    conditions_n = 4'd0; mem_read_n = 1'b0; mem_write_n = 1'b0; write_back_n = 2'd0;
    cond_branch_n = 1'b0; uncond_branch_n = 1'b0; link_branch_n = 1'b0; reg_branch_n = 1'b0;
    alu_shift_n = 1'b0; read_address1_n = 4'd0; read_address2_n = 4'd0;
    write_address_n = 4'd0; read_data1_n = 16'd0; read_data2_n = 16'd0;
    immediate_data_n = 16'd0; link_pc_n = 16'd0; memwb_RegWrite = 1'b0;
    memwb_write_address = 4'd0; memwb_write_data = 16'd0;
  endtask

  // Predict the post-edge outputs from the current inputs, clock once, compare everything
  task automatic cycle();
    logic [15:0] a, fb, b0, b, r, n_alu, n_sd, n_lpc, n_tgt;
    logic        n_rw, n_mr, n_mw, n_tk, sq, cn, vn;
    logic [1:0]  n_wb;
    logic [3:0]  n_wa, n_fl;
    int          ua, ub, sa, sb, t;
    n_rw = 0; n_mr = 0; n_mw = 0; n_tk = 0; n_wb = 0; n_wa = 0;
    n_alu = 0; n_sd = 0; n_lpc = 0; n_tgt = 0; n_fl = 0;
    if (!reset) begin
      sq = m_tk;
      a  = fwd(read_address1_n, read_data1_n);
      fb = fwd(read_address2_n, read_data2_n);
      b0 = ALUsrc_n ? immediate_data_n : fb;
      b  = alu_shift_n ? shiftv(b0, shift_type_n, int'(immediate_data_n[3:0])) : b0;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      cn = m_fl[1]; vn = m_fl[0];
      case (ALUop_n)
        3'd0: begin
          t = ua + ub; r = t[15:0]; cn = (t > 65535);
          t = sa + sb; vn = (t > 32767) || (t < -32768);
        end
        3'd1, 3'd6: begin
          t = ua - ub; r = t[15:0]; cn = (ua >= ub);
          t = sa - sb; vn = (t > 32767) || (t < -32768);
        end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = b;
        default: r = ~b;
      endcase
      n_fl = m_fl;
      if (!sq && (RegWrite_n || ALUop_n == 3'd6)) n_fl = {r[15], r == 16'd0, cn, vn};
      if (!sq) begin
        n_rw = RegWrite_n; n_mr = mem_read_n; n_mw = mem_write_n; n_wb = write_back_n;
        n_wa = write_address_n; n_alu = (ALUop_n == 3'd6) ? a : r; n_sd = fb;
        n_lpc = link_pc_n;
        n_tk = uncond_branch_n || link_branch_n || reg_branch_n ||
               (cond_branch_n && model_cond(m_fl, conditions_n));
        n_tgt = reg_branch_n ? a : 16'(link_pc_n + immediate_data_n);
      end
    end
    @(posedge clk);
    #1;
    m_rw = n_rw; m_mr = n_mr; m_mw = n_mw; m_wb = n_wb; m_wa = n_wa; m_alu = n_alu;
    m_sd = n_sd; m_lpc = n_lpc; m_tk = n_tk; m_tgt = n_tgt; m_fl = n_fl;
    chk("RegWrite_m", 16'(RegWrite_m), 16'(m_rw));
    chk("mem_read_m", 16'(mem_read_m), 16'(m_mr));
    chk("mem_write_m", 16'(mem_write_m), 16'(m_mw));
    chk("write_back_m", 16'(write_back_m), 16'(m_wb));
    chk("write_address_m", 16'(write_address_m), 16'(m_wa));
    chk("alu_result_m", alu_result_m, m_alu);
    chk("store_data_m", store_data_m, m_sd);
    chk("link_pc_m", link_pc_m, m_lpc);
    chk("branch_taken_m", 16'(branch_taken_m), 16'(m_tk));
    chk("branch_target_m", branch_target_m, m_tgt);
    chk("flags", 16'(flags), 16'(m_fl));
  endtask

  task automatic add_op(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                        input logic [15:0] da, input logic [15:0] db);
    clr();
    RegWrite_n = 1'b1; ALUop_n = 3'd0;
    read_address1_n = ra; read_address2_n = rb; write_address_n = rd;
    read_data1_n = da; read_data2_n = db;
  endtask

  initial begin
    m_rw = 0; m_mr = 0; m_mw = 0; m_tk = 0; m_wb = 0; m_wa = 0;
    m_alu = 0; m_sd = 0; m_lpc = 0; m_tgt = 0; m_fl = 0;
    clr();
    reset = 1'b1;
    uncond_branch_n = 1'b1; RegWrite_n = 1'b1; read_data1_n = 16'h1234;
    cycle();
    cycle();
    chk("reset_flags", 16'(flags), 16'h0000);
    chk("reset_alu", alu_result_m, 16'h0000);
    chk("reset_taken", 16'(branch_taken_m), 16'h0000);
    reset = 1'b0;

    // 0x7FFF + 1 overflows into the sign bit
    add_op(4'd1, 4'd2, 4'd5, 16'h7FFF, 16'h0001);
    cycle();
    chk("add_ovf_result", alu_result_m, 16'h8000);
    chk("add_ovf_flags", 16'(flags), 16'h0009);

    // Bubble leaves flags and produces all-zero outputs
    clr();
    cycle();
    chk("bubble_flags", 16'(flags), 16'h0009);
    chk("bubble_rw", 16'(RegWrite_m), 16'h0000);
    chk("bubble_alu", alu_result_m, 16'h0000);

    // CMP 5,5 then BEQ, then a wrong-path ADD
    clr();
    ALUop_n = 3'd6; read_address1_n = 4'd6; read_address2_n = 4'd7;
    read_data1_n = 16'd5; read_data2_n = 16'd5;
    cycle();
    chk("cmp_result", alu_result_m, 16'h0005);
    chk("cmp_flags", 16'(flags), 16'h0006);
    clr();
    cond_branch_n = 1'b1; conditions_n = 4'b0000;
    link_pc_n = 16'h0010; immediate_data_n = 16'h0004;
    cycle();
    chk("beq_taken", 16'(branch_taken_m), 16'h0001);
    chk("beq_target", branch_target_m, 16'h0014);
    add_op(4'd8, 4'd9, 4'd3, 16'h0001, 16'h0001);
    cycle();
    chk("squash_taken", 16'(branch_taken_m), 16'h0000);
    chk("squash_rw", 16'(RegWrite_m), 16'h0000);
    chk("squash_alu", alu_result_m, 16'h0000);
    chk("squash_flags", 16'(flags), 16'h0006);

    // EX/MEM forwarding, alone and against a conflicting MEM/WB match
    add_op(4'd8, 4'd9, 4'd3, 16'h0001, 16'h0001);
    cycle();
    chk("fwd_first", alu_result_m, 16'h0002);
    add_op(4'd3, 4'd3, 4'd4, 16'h0000, 16'h0000);
    cycle();
    chk("fwd_exmem", alu_result_m, 16'h0004);
    add_op(4'd8, 4'd9, 4'd3, 16'h0001, 16'h0001);
    cycle();
    add_op(4'd3, 4'd3, 4'd4, 16'h0000, 16'h0000);
    memwb_RegWrite = 1'b1; memwb_write_address = 4'd3; memwb_write_data = 16'h00FF;
    cycle();
    chk("fwd_priority", alu_result_m, 16'h0004);

    // Shifter through MOV
    clr();
    ALUop_n = 3'd5; alu_shift_n = 1'b1; shift_type_n = 2'b10;
    read_address2_n = 4'd10; read_data2_n = 16'h8000; immediate_data_n = 16'h0004;
    cycle();
    chk("asr", alu_result_m, 16'hF800);
    clr();
    ALUop_n = 3'd5; alu_shift_n = 1'b1; shift_type_n = 2'b11;
    read_address2_n = 4'd10; read_data2_n = 16'h0001; immediate_data_n = 16'h0001;
    cycle();
    chk("ror", alu_result_m, 16'h8000);

    // Reset wins over a branch that would otherwise register
    clr();
    uncond_branch_n = 1'b1; link_pc_n = 16'h0020; reset = 1'b1;
    cycle();
    chk("rst_br_taken", 16'(branch_taken_m), 16'h0000);
    chk("rst_br_flags", 16'(flags), 16'h0000);
    chk("rst_br_target", branch_target_m, 16'h0000);
    reset = 1'b0;

    // Randomized traffic with narrow register indices to provoke forwarding
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 63) == 0);
      RegWrite_n       = 1'($urandom);
      ALUsrc_n         = 1'($urandom);
      shift_type_n     = 2'($urandom);
      ALUop_n          = 3'($urandom);
      conditions_n     = 4'($urandom);
      mem_read_n       = 1'($urandom);
      mem_write_n      = 1'($urandom);
      write_back_n     = 2'($urandom);
      cond_branch_n    = ($urandom_range(0, 3) == 0);
      uncond_branch_n  = ($urandom_range(0, 15) == 0);
      link_branch_n    = ($urandom_range(0, 15) == 0);
      reg_branch_n     = ($urandom_range(0, 15) == 0);
      alu_shift_n      = 1'($urandom);
      read_address1_n  = 4'($urandom_range(0, 3));
      read_address2_n  = 4'($urandom_range(0, 3));
      write_address_n  = 4'($urandom_range(0, 3));
      read_data1_n     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      read_data2_n     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      immediate_data_n = 16'($urandom);
      link_pc_n        = 16'($urandom);
      memwb_RegWrite   = 1'($urandom);
      memwb_write_address = 4'($urandom_range(0, 3));
      memwb_write_data = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
